// File: rtl/ext_bus_ctrl.sv
// External multiplexed address/data bus controller: one request becomes ALE, data and turnaround beats.
// Latency: n_beats*(ALE_PHASES+1+WAIT_STATES+1)+1 cycles from acceptance to the ready pulse; all outputs registered.
// Backpressure: valid is only accepted in IDLE; requests presented while busy (including DONE) are not taken.
module ext_bus_ctrl #(
  parameter int BUS_WIDTH   = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int ALE_PHASES  = 2,
  parameter int WAIT_STATES = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid,
  output logic                    ready,
  input  logic                    rw,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   dtw,
  output logic [DATA_WIDTH-1:0]   dtr,
  output logic                    busy,
  input  logic [BUS_WIDTH-1:0]    din,
  output logic [BUS_WIDTH-1:0]    dout,
  output logic                    isout,
  output logic [ALE_PHASES-1:0]   ale,
  output logic                    oe,
  output logic                    we,
  output logic                    bhe,
  output logic                    ble
);

  localparam int BL    = BUS_WIDTH / 8;
  localparam int BEATS = DATA_WIDTH / BUS_WIDTH;
  localparam int NBE   = DATA_WIDTH / 8;
  localparam int BTW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = $clog2(ALE_PHASES + WAIT_STATES + 2);
  localparam int AEW   = ALE_PHASES * BUS_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_HOLD, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [BTW-1:0]        beat_q, beat_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NBE-1:0]        be_q, be_d;
  logic [DATA_WIDTH-1:0] dtw_q, dtw_d;
  logic                  rw_q, rw_d;
  logic [DATA_WIDTH-1:0] dtr_q, dtr_d;
  int                    nb;

  logic                  ready_q, ready_d, busy_q, busy_d, isout_q, isout_d;
  logic                  oe_q, oe_d, we_q, we_d, bhe_q, bhe_d, ble_q, ble_d;
  logic [ALE_PHASES-1:0] ale_q, ale_d;
  logic [BUS_WIDTH-1:0]  dout_q, dout_d;

  logic [1:0]            lanes;
  logic [BUS_WIDTH-1:0]  bdat;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [AEW-1:0]        addr_ext;

  // Lowest beat index >= start whose byte lanes are not all disabled; -1 if none remain.
  function automatic int next_beat(input logic [NBE-1:0] bev, input int start);
    int r;
    r = -1;
    for (int b = BEATS - 1; b >= 0; b--) begin
      if (b >= start && (|bev[b*BL +: BL])) r = b;
    end
    return r;
  endfunction

  // Next-state: walk ADDR phases, DATA wait cycles and HOLD per beat, skipping empty beats.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    be_d    = be_q;
    dtw_d   = dtw_q;
    rw_d    = rw_q;
    dtr_d   = dtr_q;
    nb      = -1;
    unique case (state_q)
      S_IDLE: begin
        if (valid) begin
          addr_d = addr;
          be_d   = be;
          dtw_d  = dtw;
          rw_d   = rw;
          dtr_d  = '0;
          nb     = next_beat(be, 0);
          cnt_d  = '0;
          if (nb >= 0) begin
            state_d = S_ADDR;
            beat_d  = BTW'(nb);
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ADDR: begin
        if (cnt_q == CW'(ALE_PHASES - 1)) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == CW'(WAIT_STATES)) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          // Read data is captured at the end of the final wait cycle; disabled lanes keep their cleared value.
          if (!rw_q) begin
            for (int b = 0; b < BEATS; b++) begin
              for (int l = 0; l < BL; l++) begin
                if (int'(beat_q) == b && be_q[b*BL + l]) dtr_d[(b*BL + l)*8 +: 8] = din[l*8 +: 8];
              end
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        nb = next_beat(be_q, int'(beat_q) + 1);
        if (nb >= 0) begin
          state_d = S_ADDR;
          beat_d  = BTW'(nb);
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state, so every pad-facing signal comes straight from a flop.
  always_comb begin
    ready_d   = 1'b0;
    isout_d   = 1'b0;
    ale_d     = '0;
    oe_d      = 1'b0;
    we_d      = 1'b0;
    bhe_d     = 1'b0;
    ble_d     = 1'b0;
    dout_d    = '0;
    lanes     = '0;
    bdat      = '0;
    beat_addr = (addr_d & ~ADDR_WIDTH'(NBE - 1)) + ADDR_WIDTH'(int'(beat_d) * BL);
    addr_ext  = '0;
    addr_ext[ADDR_WIDTH-1:0] = beat_addr;
    for (int b = 0; b < BEATS; b++) begin
      if (int'(beat_d) == b) begin
        bdat = dtw_d[b*BUS_WIDTH +: BUS_WIDTH];
        for (int l = 0; l < BL; l++) lanes[l] = be_d[b*BL + l];
      end
    end
    case (state_d)
      S_ADDR: begin
        isout_d = 1'b1;
        for (int p = 0; p < ALE_PHASES; p++) begin
          if (int'(cnt_d) == p) begin
            ale_d[p] = 1'b1;
            dout_d   = addr_ext[p*BUS_WIDTH +: BUS_WIDTH];
          end
        end
      end
      S_DATA: begin
        ble_d = lanes[0];
        bhe_d = lanes[1];
        if (rw_d) begin
          we_d    = 1'b1;
          isout_d = 1'b1;
          dout_d  = bdat;
        end else begin
          oe_d = 1'b1;
        end
      end
      S_HOLD: begin
        // Writes keep driving the bus through turnaround so the device sees stable data after we falls.
        if (rw_d) begin
          isout_d = 1'b1;
          dout_d  = bdat;
        end
      end
      S_DONE:  ready_d = 1'b1;
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State, captured request and registered outputs; reset aborts any transfer in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      dtw_q   <= '0;
      rw_q    <= 1'b0;
      dtr_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      isout_q <= 1'b0;
      ale_q   <= '0;
      oe_q    <= 1'b0;
      we_q    <= 1'b0;
      bhe_q   <= 1'b0;
      ble_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      dtw_q   <= dtw_d;
      rw_q    <= rw_d;
      dtr_q   <= dtr_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      isout_q <= isout_d;
      ale_q   <= ale_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      bhe_q   <= bhe_d;
      ble_q   <= ble_d;
      dout_q  <= dout_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign isout = isout_q;
  assign ale   = ale_q;
  assign oe    = oe_q;
  assign we    = we_q;
  assign bhe   = bhe_q;
  assign ble   = ble_q;
  assign dout  = dout_q;
  assign dtr   = dtr_q;

endmodule
